sram_kn_reader: RTL and testbench
=================================

Name: sram_kn_reader

Overview:
- Read initiator for the K×N k/n-addressed SRAM port (x_en/x_re/x_we/x_k/x_n/x_wdata/x_wmask in, x_rdata/x_rvalid out; 1-cycle read latency).
- Accepts a rectangular sub-tile command, sequences reads in a selectable loop order, and delivers the words as a valid/ready stream through a credit-guarded FIFO.
- Feeds the MAC array operand path with K×N weight/activation tiles.

Parameters:
- KMAX, 1024, number of k rows in the memory.
- N, 8, number of n columns in the memory.
- DATA_W, 32, word width.
- BYTE_W, DATA_W/8, write-mask width. Mask outputs are driven to zero.
- K_W, (KMAX<=1)?1:$clog2(KMAX), k index width.
- N_W, (N<=1)?1:$clog2(N), n index width.
- FIFO_DEPTH, 4, output buffer depth. Power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid&&ready.
- cmd_k0  in  K_W  start k.
- cmd_klen  in  K_W+1  number of k rows.
- cmd_n0  in  N_W  start n.
- cmd_nlen  in  N_W+1  number of n columns.
- cmd_order  in  1  0 = n inner loop, 1 = k inner loop.
- x_en  out  1  memory access enable.
- x_re  out  1  memory read (equals x_en).
- x_we  out  1  constant 0.
- x_k  out  K_W  read k.
- x_n  out  N_W  read n.
- x_wdata  out  DATA_W  constant 0.
- x_wmask  out  BYTE_W  constant 0.
- x_rdata  in  DATA_W  read data.
- x_rvalid  in  1  read data valid, one cycle after x_en.
- o_valid  out  1  stream valid.
- o_ready  in  1  stream ready.
- o_data  out  DATA_W  stream word.
- o_last  out  1  final word of the tile.
- busy  out  1  a command is in progress.
- done  out  1  one-cycle pulse when the last word is handshaken.
- err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - cmd_ready=1. x_en=x_re=0. o_valid=0. o_last=0. busy=done=err=0.
  - FIFO empty. Credit and in-flight counters 0. x_k=x_n=0.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On handshake, validate: klen≠0, nlen≠0, k0+klen≤KMAX, n0+nlen≤N.
  - Invalid command: err pulses in the next cycle; stay IDLE.
  - Valid command: latch the fields, load kc=k0 and nc=n0, go to ISSUE. busy=1 from the next cycle.
- ISSUE:
  - Issue condition: fifo_count + inflight < FIFO_DEPTH.
  - When the condition holds, drive x_en=x_re=1 with x_k=kc, x_n=nc, and advance the counters.
  - Inner counter wraps to its start value; on wrap, the outer counter increments.
  - Tag the last address (both counters at their final values); the tag travels in a 1-deep pipeline alongside the read.
  - After the last address is issued, go to DRAIN.
  - cmd_ready=0 in ISSUE and DRAIN.
- Credit: inflight is at most 1 (1-cycle latency). fifo_count + inflight never exceeds FIFO_DEPTH, so x_rvalid data is never dropped.
- On x_rvalid: push {x_rdata, tag} into the FIFO. The FIFO is first-word fall-through; o_valid is asserted in the cycle after the push.
- Stream rules:
  - Pop on o_valid&&o_ready.
  - o_data and o_last hold stable while o_valid&&!o_ready.
  - Push and pop in the same cycle are allowed when the FIFO is full, and when it is empty: the pushed word becomes visible next cycle.
- DRAIN: when a tagged word is popped, done pulses in the next cycle, busy drops, and the state returns to IDLE.
- Throughput: with o_ready held at 1, one word per cycle.
  - Latency: handshake at cycle 0 → first x_en at cycle 1 → x_rvalid at cycle 2 → first o_valid at cycle 3.
- Address order for klen=2, nlen=2 from (k0,n0):
  - order=0: (k0,n0), (k0,n0+1), (k0+1,n0), (k0+1,n0+1).
  - order=1: (k0,n0), (k0+1,n0), (k0,n0+1), (k0+1,n0+1).
- Reset mid-operation clears all state immediately. Words in flight are discarded; a late x_rvalid after reset is ignored.
- A stray x_rvalid with inflight=0 is ignored.

Test Plan:
- Memory preloaded word(k,n)=k*16+n; cmd k0=3,klen=2,n0=1,nlen=3,order=0, o_ready=1 → o_data 0x31,0x32,0x33,0x41,0x42,0x43; o_last only on 0x43; done one cycle after it; first o_valid 3 cycles after the command handshake.
- Same command with order=1 → 0x31,0x41,0x32,0x42,0x33,0x43.
- o_ready=0 for 10 cycles after the command → exactly FIFO_DEPTH=4 reads issued, then x_en stays 0; release o_ready → remaining words arrive in order with no loss or duplication.
- cmd k0=1020,klen=8 (KMAX=1024) → err pulse, no x_en, cmd_ready stays 1; cmd with nlen=0 → err pulse.
- rst_n asserted low after 3 of 6 words have been issued → o_valid=0, busy=0, and FIFO empty immediately; a new command afterwards reads the correct full tile.
- Single-word cmd klen=1,nlen=1 at (k=1023,n=7) → one word with o_last=1, done pulse, no counter wrap artefact.

Source files
------------

// File: rtl/sram_kn_reader.sv
// sram_kn_reader: read initiator for the K x N k/n-addressed SRAM port.
// Accepts a rectangular sub-tile command and walks it in n-inner or k-inner
// order. Read data is delivered as a valid/ready stream through a small
// first-word-fall-through FIFO. A credit check holds back reads so that
// returning data always has a free FIFO slot.
module sram_kn_reader #(
   parameter int KMAX       = 1024,
   parameter int N          = 8,
   parameter int DATA_W     = 32,
   parameter int BYTE_W     = DATA_W/8,
   parameter int K_W        = (KMAX <= 1) ? 1 : $clog2(KMAX),
   parameter int N_W        = (N <= 1) ? 1 : $clog2(N),
   parameter int FIFO_DEPTH = 4
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [K_W-1:0]    cmd_k0,
   input  logic [K_W:0]      cmd_klen,
   input  logic [N_W-1:0]    cmd_n0,
   input  logic [N_W:0]      cmd_nlen,
   input  logic              cmd_order,
   output logic              x_en,
   output logic              x_re,
   output logic              x_we,
   output logic [K_W-1:0]    x_k,
   output logic [N_W-1:0]    x_n,
   output logic [DATA_W-1:0] x_wdata,
   output logic [BYTE_W-1:0] x_wmask,
   input  logic [DATA_W-1:0] x_rdata,
   input  logic              x_rvalid,
   output logic              o_valid,
   input  logic              o_ready,
   output logic [DATA_W-1:0] o_data,
   output logic              o_last,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int PTR_W = (FIFO_DEPTH <= 2) ? 1 : $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic [K_W+1:0] KMAX_L  = (K_W+2)'(KMAX);
   localparam logic [N_W+1:0] NMAX_L  = (N_W+2)'(N);
   localparam logic [CNT_W:0] DEPTH_O = (CNT_W+1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   // A command is legal when both extents are non-zero and the tile stays
   // inside the memory. Sums are widened so the bound check cannot wrap.
   function automatic logic f_cmd_ok(input logic [K_W-1:0] k0,
                                     input logic [K_W:0]   klen,
                                     input logic [N_W-1:0] n0,
                                     input logic [N_W:0]   nlen);
      logic [K_W+1:0] k_end;
      logic [N_W+1:0] n_end;
      k_end    = {2'b00, k0} + {1'b0, klen};
      n_end    = {2'b00, n0} + {1'b0, nlen};
      f_cmd_ok = (klen != '0) && (nlen != '0) &&
                 (k_end <= KMAX_L) && (n_end <= NMAX_L);
   endfunction

   // Control state
   logic [1:0]     r_state;
   logic [K_W-1:0] r_kc;
   logic [N_W-1:0] r_nc;
   logic [K_W-1:0] r_k0;
   logic [N_W-1:0] r_n0;
   logic [K_W-1:0] r_k_last;
   logic [N_W-1:0] r_n_last;
   logic           r_order;
   logic           r_done;
   logic           r_err;

   // Read pipeline (one cycle of memory latency)
   logic           r_vld_p1;
   logic           r_tag_p1;

   // Output FIFO: each entry is {data, last-tag}
   logic [DATA_W:0]  r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic           w_cmd_hs;
   logic           w_cmd_ok;
   logic [K_W-1:0] w_k_last;
   logic [N_W-1:0] w_n_last;
   logic [CNT_W:0] w_occ;
   logic           w_credit_ok;
   logic           w_issue;
   logic           w_k_end;
   logic           w_n_end;
   logic           w_last_addr;
   logic           w_push;
   logic           w_push_acc;
   logic           w_pop;
   logic [DATA_W:0] w_head;
   logic           w_head_last;

   assign cmd_ready = (r_state == S_IDLE);
   assign w_cmd_hs  = cmd_valid && cmd_ready;
   assign w_cmd_ok  = f_cmd_ok(cmd_k0, cmd_klen, cmd_n0, cmd_nlen);
   assign w_k_last  = cmd_k0 + cmd_klen[K_W-1:0] - K_W'(1);
   assign w_n_last  = cmd_n0 + cmd_nlen[N_W-1:0] - N_W'(1);

   // Words already buffered plus the one possibly in flight must leave a slot
   assign w_occ       = {1'b0, r_count} + {{CNT_W{1'b0}}, r_vld_p1};
   assign w_credit_ok = (w_occ < DEPTH_O);
   assign w_issue     = (r_state == S_ISSUE) && w_credit_ok;

   assign w_k_end     = (r_kc == r_k_last);
   assign w_n_end     = (r_nc == r_n_last);
   assign w_last_addr = w_k_end && w_n_end;

   assign w_push      = x_rvalid && r_vld_p1;
   assign w_pop       = o_valid && o_ready;
   assign w_push_acc  = w_push && ((r_count != DEPTH_C) || w_pop);
   assign w_head      = r_mem[r_rd_ptr];
   assign w_head_last = w_head[0];

   // Memory port: read-only initiator, write side tied off
   assign x_en    = w_issue;
   assign x_re    = w_issue;
   assign x_we    = 1'b0;
   assign x_k     = r_kc;
   assign x_n     = r_nc;
   assign x_wdata = '0;
   assign x_wmask = '0;

   // Stream side
   assign o_valid = (r_count != '0);
   assign o_data  = w_head[DATA_W:1];
   assign o_last  = o_valid && w_head_last;
   assign busy    = (r_state != S_IDLE);
   assign done    = r_done;
   assign err     = r_err;

   // Sequencer FSM plus done/err pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_cmd_hs) begin
                  if (w_cmd_ok) r_state <= S_ISSUE;
                  else          r_err   <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (w_issue && w_last_addr) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (w_pop && w_head_last) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Latch the accepted tile geometry and loop order
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k0     <= '0;
         r_n0     <= '0;
         r_k_last <= '0;
         r_n_last <= '0;
         r_order  <= 1'b0;
      end else if (w_cmd_hs && w_cmd_ok) begin
         r_k0     <= cmd_k0;
         r_n0     <= cmd_n0;
         r_k_last <= w_k_last;
         r_n_last <= w_n_last;
         r_order  <= cmd_order;
      end
   end

   // Address walk: inner counter wraps to its start, then outer advances.
   // The final address does not advance, so a tile ending at the top edge
   // of the memory leaves no wrapped index behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_kc <= '0;
         r_nc <= '0;
      end else if (w_cmd_hs && w_cmd_ok) begin
         r_kc <= cmd_k0;
         r_nc <= cmd_n0;
      end else if (w_issue && !w_last_addr) begin
         if (!r_order) begin
            if (w_n_end) begin
               r_nc <= r_n0;
               r_kc <= r_kc + K_W'(1);
            end else begin
               r_nc <= r_nc + N_W'(1);
            end
         end else begin
            if (w_k_end) begin
               r_kc <= r_k0;
               r_nc <= r_nc + N_W'(1);
            end else begin
               r_kc <= r_kc + K_W'(1);
            end
         end
      end
   end

   // p0 -> p1: track the outstanding read and its last-address tag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_p1 <= 1'b0;
         r_tag_p1 <= 1'b0;
      end else begin
         r_vld_p1 <= w_issue;
         r_tag_p1 <= w_issue && w_last_addr;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)      r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push_acc, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // p1 -> FIFO: capture returning read data with its tag
   always_ff @(posedge clk) begin
      if (w_push_acc) r_mem[r_wr_ptr] <= {x_rdata, r_tag_p1};
   end

endmodule

// File: tb/tb_sram_kn_reader.sv
// Self-checking bench for sram_kn_reader with a 1-cycle-latency SRAM model
// and a scoreboard of expected stream words.
module tb_sram_kn_reader;

   localparam int KMAX       = 1024;
   localparam int N          = 8;
   localparam int DATA_W     = 32;
   localparam int BYTE_W     = 4;
   localparam int K_W        = 10;
   localparam int N_W        = 3;
   localparam int FIFO_DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [K_W-1:0]    cmd_k0 = '0;
   logic [K_W:0]      cmd_klen = '0;
   logic [N_W-1:0]    cmd_n0 = '0;
   logic [N_W:0]      cmd_nlen = '0;
   logic              cmd_order = 1'b0;
   logic              x_en, x_re, x_we;
   logic [K_W-1:0]    x_k;
   logic [N_W-1:0]    x_n;
   logic [DATA_W-1:0] x_wdata;
   logic [BYTE_W-1:0] x_wmask;
   logic [DATA_W-1:0] x_rdata = '0;
   logic              x_rvalid = 1'b0;
   logic              o_valid;
   logic              o_ready = 1'b0;
   logic [DATA_W-1:0] o_data;
   logic              o_last;
   logic              busy, done, err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int hs_cyc = 0;
   int first_vld_cyc = -1;
   int last_pop_cyc = -1;
   int done_cyc = -1;
   bit done_seen = 1'b0;
   int en_cnt = 0;
   logic [DATA_W:0] exp_q[$];

   sram_kn_reader #(
      .KMAX(KMAX), .N(N), .DATA_W(DATA_W), .BYTE_W(BYTE_W),
      .K_W(K_W), .N_W(N_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_k0(cmd_k0), .cmd_klen(cmd_klen), .cmd_n0(cmd_n0),
      .cmd_nlen(cmd_nlen), .cmd_order(cmd_order),
      .x_en(x_en), .x_re(x_re), .x_we(x_we), .x_k(x_k), .x_n(x_n),
      .x_wdata(x_wdata), .x_wmask(x_wmask),
      .x_rdata(x_rdata), .x_rvalid(x_rvalid),
      .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] word(input int k, input int n);
      return DATA_W'(k * 16 + n);
   endfunction

   // SRAM model: word(k,n)=k*16+n, one cycle read latency
   always @(posedge clk) begin
      x_rvalid <= x_en;
      x_rdata  <= word(int'(x_k), int'(x_n));
      cyc      <= cyc + 1;
   end

   // Output monitor: pops the scoreboard on every stream handshake
   always @(negedge clk) begin
      logic [DATA_W:0] e;
      if (rst_n) begin
         if (x_en) en_cnt++;
         if (o_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
         if (done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
         end
         if (o_valid && o_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL stream_extra: got data=%h last=%b, required no word", o_data, o_last);
            end else begin
               e = exp_q.pop_front();
               if (o_data !== e[DATA_W:1] || o_last !== e[0]) begin
                  n_fail++;
                  $display("FAIL stream_word: got data=%h last=%b, required data=%h last=%b",
                           o_data, o_last, e[DATA_W:1], e[0]);
               end
            end
            if (o_last) last_pop_cyc = cyc;
         end
      end
   end

   task automatic push_tile(input int k0, input int klen, input int n0, input int nlen, input int ord);
      int total, idx;
      total = klen * nlen;
      idx = 0;
      if (ord == 0) begin
         for (int k = k0; k < k0 + klen; k++)
            for (int n = n0; n < n0 + nlen; n++) begin
               idx++;
               exp_q.push_back({word(k, n), idx == total});
            end
      end else begin
         for (int n = n0; n < n0 + nlen; n++)
            for (int k = k0; k < k0 + klen; k++) begin
               idx++;
               exp_q.push_back({word(k, n), idx == total});
            end
      end
   endtask

   task automatic send_cmd(input int k0, input int klen, input int n0, input int nlen, input int ord);
      @(posedge clk); #1;
      cmd_k0    = K_W'(k0);
      cmd_klen  = (K_W+1)'(klen);
      cmd_n0    = N_W'(n0);
      cmd_nlen  = (N_W+1)'(nlen);
      cmd_order = ord[0];
      cmd_valid = 1'b1;
      hs_cyc    = cyc;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic clear_obs();
      done_seen = 1'b0;
      first_vld_cyc = -1;
      last_pop_cyc = -1;
      done_cyc = -1;
      en_cnt = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({cmd_ready, x_en, x_re, o_valid, o_last, busy, done, err} !== 8'b1000_0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b, required 10000000",
                  {cmd_ready, x_en, x_re, o_valid, o_last, busy, done, err});
      end
      n_tests++;
      if (x_k !== '0 || x_n !== '0) begin
         n_fail++;
         $display("FAIL reset_addr: got k=%0d n=%0d, required 0 0", x_k, x_n);
      end
      n_tests++;
      if (x_we !== 1'b0 || x_wdata !== '0 || x_wmask !== '0) begin
         n_fail++;
         $display("FAIL reset_wside: got we=%b wdata=%h wmask=%h, required zeros", x_we, x_wdata, x_wmask);
      end
      rst_n = 1'b1;
      @(negedge clk); #1;
      n_tests++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_idle: got ready=%b busy=%b vld=%b, required 1 0 0", cmd_ready, busy, o_valid);
      end
   endtask

   task automatic test_order(input int ord);
      o_ready = 1'b1;
      clear_obs();
      push_tile(3, 2, 1, 3, ord);
      send_cmd(3, 2, 1, 3, ord);
      for (int i = 0; i < 200 && !done_seen; i++) begin @(negedge clk); #1; end
      n_tests++;
      if (!done_seen) begin
         n_fail++;
         $display("FAIL order%0d_done: got no done pulse, required one", ord);
      end
      n_tests++;
      if (first_vld_cyc - hs_cyc != 3) begin
         n_fail++;
         $display("FAIL order%0d_latency: got %0d cycles, required 3", ord, first_vld_cyc - hs_cyc);
      end
      n_tests++;
      if (done_cyc != last_pop_cyc + 1) begin
         n_fail++;
         $display("FAIL order%0d_done_timing: got done at %0d last pop at %0d, required one cycle later",
                  ord, done_cyc, last_pop_cyc);
      end
      n_tests++;
      if (exp_q.size() != 0 || en_cnt != 6 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL order%0d_complete: got left=%0d reads=%0d busy=%b, required 0 6 0",
                  ord, exp_q.size(), en_cnt, busy);
      end
      @(negedge clk); #1;
      n_tests++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL order%0d_done_pulse: got done=%b one cycle later, required 0", ord, done);
      end
   endtask

   task automatic test_backpressure();
      logic [DATA_W-1:0] held;
      o_ready = 1'b0;
      clear_obs();
      exp_q.delete();
      push_tile(3, 2, 1, 3, 0);
      send_cmd(3, 2, 1, 3, 0);
      repeat (4) begin @(negedge clk); #1; end
      held = o_data;
      repeat (6) begin @(negedge clk); #1; end
      n_tests++;
      if (en_cnt != FIFO_DEPTH) begin
         n_fail++;
         $display("FAIL bp_reads: got %0d reads, required %0d", en_cnt, FIFO_DEPTH);
      end
      n_tests++;
      if (x_en !== 1'b0 || o_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_stall: got x_en=%b o_valid=%b, required 0 1", x_en, o_valid);
      end
      n_tests++;
      if (o_data !== held || o_data !== 32'h31) begin
         n_fail++;
         $display("FAIL bp_hold: got %h (earlier %h), required 00000031", o_data, held);
      end
      @(posedge clk); #1;
      o_ready = 1'b1;
      for (int i = 0; i < 200 && !done_seen; i++) begin @(negedge clk); #1; end
      n_tests++;
      if (!done_seen || exp_q.size() != 0 || en_cnt != 6) begin
         n_fail++;
         $display("FAIL bp_release: got done=%b left=%0d reads=%0d, required 1 0 6",
                  done_seen, exp_q.size(), en_cnt);
      end
   endtask

   task automatic test_invalid();
      o_ready = 1'b1;
      clear_obs();
      send_cmd(1020, 8, 0, 1, 0);
      n_tests++;
      if (err !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL inv_krange: got err=%b ready=%b busy=%b, required 1 1 0", err, cmd_ready, busy);
      end
      repeat (5) begin @(negedge clk); #1; end
      n_tests++;
      if (err !== 1'b0 || en_cnt != 0) begin
         n_fail++;
         $display("FAIL inv_quiet: got err=%b reads=%0d, required 0 0", err, en_cnt);
      end
      send_cmd(0, 1, 0, 0, 0);
      n_tests++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL inv_nlen0: got err=%b, required 1", err);
      end
      send_cmd(0, 1, 6, 3, 1);
      n_tests++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL inv_nrange: got err=%b busy=%b, required 1 0", err, busy);
      end
      repeat (3) begin @(negedge clk); #1; end
      n_tests++;
      if (en_cnt != 0 || o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL inv_noread: got reads=%0d o_valid=%b, required 0 0", en_cnt, o_valid);
      end
   endtask

   task automatic test_reset_mid();
      o_ready = 1'b1;
      clear_obs();
      exp_q.delete();
      push_tile(3, 2, 1, 3, 0);
      send_cmd(3, 2, 1, 3, 0);
      for (int i = 0; i < 20 && en_cnt < 3; i++) begin @(negedge clk); #1; end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (o_valid !== 1'b0 || busy !== 1'b0 || x_en !== 1'b0 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset: got vld=%b busy=%b x_en=%b ready=%b, required 0 0 0 1",
                  o_valid, busy, x_en, cmd_ready);
      end
      exp_q.delete();
      #1;
      rst_n = 1'b1;
      @(negedge clk); #1;
      n_tests++;
      if (o_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_late_rvalid: got vld=%b busy=%b, required 0 0", o_valid, busy);
      end
      clear_obs();
      push_tile(3, 2, 1, 3, 1);
      send_cmd(3, 2, 1, 3, 1);
      for (int i = 0; i < 200 && !done_seen; i++) begin @(negedge clk); #1; end
      n_tests++;
      if (!done_seen || exp_q.size() != 0 || en_cnt != 6) begin
         n_fail++;
         $display("FAIL mid_recover: got done=%b left=%0d reads=%0d, required 1 0 6",
                  done_seen, exp_q.size(), en_cnt);
      end
   endtask

   task automatic test_single();
      o_ready = 1'b1;
      clear_obs();
      exp_q.delete();
      push_tile(1023, 1, 7, 1, 0);
      send_cmd(1023, 1, 7, 1, 0);
      for (int i = 0; i < 100 && !done_seen; i++) begin @(negedge clk); #1; end
      n_tests++;
      if (!done_seen || exp_q.size() != 0 || en_cnt != 1) begin
         n_fail++;
         $display("FAIL single_word: got done=%b left=%0d reads=%0d, required 1 0 1",
                  done_seen, exp_q.size(), en_cnt);
      end
      n_tests++;
      if (x_k !== 10'd1023 || x_n !== 3'd7 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_nowrap: got k=%0d n=%0d busy=%b, required 1023 7 0", x_k, x_n, busy);
      end
   endtask

   initial begin
      test_reset();
      test_order(0);
      test_order(1);
      test_backpressure();
      test_invalid();
      test_reset_mid();
      test_single();
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000, required finish");
      $fatal(1, "timeout");
   end

endmodule
